instruction_fetch: RTL

Fetch stage that sits directly upstream of the 128 x 16 instruction memory. It owns the program counter, drives the memory's `addr`/`rd` pins and captures the returned word into an instruction register. The instruction register feeds decode through a valid/ready handshake. The block accepts PC redirects from execute (branches) and halts after fetching a word whose stop bit (bit 0) is 1.

---
 rtl/instruction_fetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, imem read, instruction register with valid/ready
// Stops after a word with bit 0 set; execute redirects restart fetching from any non-IDLE state.
module instruction_fetch #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              slot_free;
    logic              capture;

    assign slot_free = !ir_valid_q || ir_ready;
    assign capture   = (state_q == S_FETCH) && slot_free && !redirect;

    assign imem_addr = pc_q;
    assign imem_rd   = capture;
    assign ir_valid  = ir_valid_q;
    assign ir_data   = ir_data_q;
    assign ir_pc     = ir_pc_q;
    assign halted    = (state_q == S_HALT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;

        if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_HALT: begin
                // Redirect wins over capture and flushes the slot; a same-cycle
                // handshake still counts as a transfer on the decode side.
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (capture) begin
                    ir_data_d  = imem_rdata;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(1);
                    if (imem_rdata[0]) begin
                        state_d = S_HALT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

endmodule
